// File: rtl/rv_mem_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package rv_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, REQ, RESP, ACK} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick between fetch and data requesters.
module rr_arbiter2 (
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic gnt_valid,
  output logic gnt_d
);
  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_d     = 1'b0;
    if (i_req && d_req) gnt_d = ~last_d;
    else if (d_req)     gnt_d = 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with one outstanding
// transaction, round-robin arbitration and a request-phase timeout.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int STRB_W = DATA_W / 8;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  arb_state_t state, state_nxt;
  req_id_t last_grant, last_grant_nxt, owner, owner_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic gnt_valid, gnt_d;

  logic              mem_req_nxt, mem_we_nxt, busy_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [STRB_W-1:0] mem_wstrb_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic              i_ack_nxt, i_err_nxt, d_ack_nxt, d_err_nxt;

  rr_arbiter2 u_rr (
    .i_req     (i_req),
    .d_req     (d_req),
    .last_d    (last_grant == REQ_D),
    .gnt_valid (gnt_valid),
    .gnt_d     (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_D;
      owner      <= REQ_I;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      i_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wstrb  <= mem_wstrb_nxt;
      mem_wdata  <= mem_wdata_nxt;
      i_ack      <= i_ack_nxt;
      i_err      <= i_err_nxt;
      i_rdata    <= i_rdata_nxt;
      d_ack      <= d_ack_nxt;
      d_err      <= d_err_nxt;
      d_rdata    <= d_rdata_nxt;
      busy       <= busy_nxt;
    end
  end

  // Completion outputs default to 0, so they form a single-cycle pulse in ACK.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    tmo_cnt_nxt    = tmo_cnt;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wstrb_nxt  = mem_wstrb;
    mem_wdata_nxt  = mem_wdata;
    i_ack_nxt      = 1'b0;
    i_err_nxt      = 1'b0;
    i_rdata_nxt    = '0;
    d_ack_nxt      = 1'b0;
    d_err_nxt      = 1'b0;
    d_rdata_nxt    = '0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          owner_nxt      = gnt_d ? REQ_D : REQ_I;
          last_grant_nxt = gnt_d ? REQ_D : REQ_I;
          mem_req_nxt    = 1'b1;
          tmo_cnt_nxt    = '0;
          state_nxt      = REQ;
          if (gnt_d) begin
            mem_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wstrb_nxt = d_wstrb;
            mem_wdata_nxt = d_wdata;
          end else begin
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = i_addr;
            mem_wstrb_nxt = '1;
            mem_wdata_nxt = '0;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_req_nxt = 1'b0;
          state_nxt   = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          // Memory never accepted, so aborting leaves nothing in flight.
          mem_req_nxt = 1'b0;
          state_nxt   = ACK;
          if (owner == REQ_D) begin
            d_ack_nxt = 1'b1;
            d_err_nxt = 1'b1;
          end else begin
            i_ack_nxt = 1'b1;
            i_err_nxt = 1'b1;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_ONE;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_nxt = ACK;
          if (owner == REQ_D) begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = mem_we ? '0 : mem_rdata;
          end else begin
            i_ack_nxt   = 1'b1;
            i_rdata_nxt = mem_rdata;
          end
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;

  // memory responder configuration
  int          rd_cfg = 0, rv_cfg = 1;
  logic [31:0] rdata_cfg = '0;
  bit          stray_req_en = 0, stray_idle_en = 0;
  int          req_age = 0, rv_cyc = 0;
  bit          rv_pend = 0;

  // reference model: 1 = data was granted last
  bit m_last_d = 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Memory: ready after rd_cfg cycles of mem_req (never if negative), response rv_cfg later.
  always @(negedge clk) begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (rv_pend && cyc == rv_cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdata_cfg;
      rv_pend    = 0;
    end else if (stray_idle_en && !mem_req && !rv_pend && $urandom_range(0, 2) == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
    if (mem_req) begin
      if (rd_cfg >= 0 && req_age == rd_cfg) begin
        mem_ready = 1'b1;
        rv_pend   = 1;
        rv_cyc    = cyc + rv_cfg;
      end else if (stray_req_en && !mem_rvalid && $urandom_range(0, 1) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
      req_age++;
    end else begin
      req_age = 0;
    end
  end

  // Issues the requested pattern and checks every resulting grant until all are served.
  task automatic run_txn(input bit want_i, input bit want_d, input int rd, input int rv);
    bit pend_i, pend_d, win_d, got;
    int t0, exp_off, n_req;
    logic        e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_wstrb;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_noack", {i_ack, d_ack}, 0);
    rd_cfg = rd;
    rv_cfg = rv;
    i_req  = want_i;
    d_req  = want_d;
    pend_i = want_i;
    pend_d = want_d;
    t0     = cyc;
    while (pend_i || pend_d) begin
      win_d    = (pend_i && pend_d) ? !m_last_d : pend_d;
      m_last_d = win_d;
      e_we     = win_d ? d_we : 1'b0;
      e_addr   = win_d ? d_addr : i_addr;
      e_wstrb  = win_d ? d_wstrb : 4'hF;
      e_wdata  = win_d ? d_wdata : 32'h0;
      e_rdata  = (rd < 0 || e_we) ? 32'h0 : rdata_cfg;
      exp_off  = (rd < 0) ? TMO + 1 : 2 + rd + rv;
      n_req    = 0;
      got      = 0;
      for (int k = 0; k < TMO + 40 && !got; k++) begin
        @(negedge clk);
        if (mem_req) begin
          n_req++;
          check_eq("mem_addr", mem_addr, e_addr);
          check_eq("mem_we", mem_we, e_we);
          check_eq("mem_wstrb", mem_wstrb, e_wstrb);
          check_eq("mem_wdata", mem_wdata, e_wdata);
          check_eq("busy_req", busy, 1);
        end
        if (i_ack || d_ack) begin
          got = 1;
          check_eq("ack_latency", cyc - t0, exp_off);
          check_eq("ack_side", {i_ack, d_ack}, win_d ? 2'b01 : 2'b10);
          check_eq("ack_err", win_d ? d_err : i_err, rd < 0);
          check_eq("ack_rdata", win_d ? d_rdata : i_rdata, e_rdata);
          check_eq("other_quiet", win_d ? {i_err, i_rdata} : {d_err, d_rdata}, 0);
          check_eq("mem_req_len", n_req, (rd < 0) ? TMO : rd + 1);
          if (win_d) begin d_req = 0; pend_d = 0; end
          else       begin i_req = 0; pend_i = 0; end
        end
      end
      if (!got) begin
        check_eq("ack_timeout", 0, 1);
        i_req = 0; d_req = 0; pend_i = 0; pend_d = 0;
      end
      t0 = cyc + 1;
    end
  endtask

  task automatic rand_fields();
    i_addr    = $urandom;
    d_we      = $urandom_range(0, 1);
    d_addr    = $urandom;
    d_wstrb   = $urandom;
    d_wdata   = $urandom;
    rdata_cfg = $urandom;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {mem_req, mem_we, mem_addr, mem_wstrb, busy, i_ack, d_ack}, 0);
    check_eq("rst_rdata", {i_rdata, d_rdata}, 0);
    check_eq("rst_err", {i_err, d_err, mem_wdata}, 0);
    rst = 0;

    // fetch only, minimum latency
    rand_fields();
    i_addr = 32'h100; rdata_cfg = 32'hDEADBEEF;
    run_txn(1, 0, 0, 1);

    // ties alternate; interleave single requests to move last_grant
    for (int t = 0; t < 4; t++) begin
      rand_fields();
      run_txn(1, 1, t % 2, 1 + t);
      if (t == 1) begin rand_fields(); run_txn(0, 1, 0, 1); end
    end

    // store
    rand_fields();
    d_we = 1; d_wstrb = 4'b0011; d_wdata = 32'h1234;
    run_txn(0, 1, 0, 1);

    // timeout, then strays while idle and during request wait
    rand_fields();
    d_we = 0;
    run_txn(0, 1, -1, 1);
    stray_idle_en = 1;
    stray_req_en  = 1;
    repeat (4) @(negedge clk);
    check_eq("stray_idle_noack", {i_ack, d_ack, busy}, 0);

    // wait states and the last-chance accept before timeout
    rand_fields();
    run_txn(1, 0, 3, 5);
    rand_fields();
    run_txn(0, 1, TMO - 1, 2);

    for (int n = 0; n < 40; n++) begin
      int sel, rd;
      rand_fields();
      sel = $urandom_range(0, 2);
      rd  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      run_txn(sel != 1, sel != 0, rd, $urandom_range(1, 5));
    end

    // asynchronous reset while waiting for the response
    stray_idle_en = 0;
    stray_req_en  = 0;
    rand_fields();
    d_we = 0; d_addr = 32'h40; rd_cfg = 0; rv_cfg = 6;
    @(negedge clk);
    d_req = 1;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    check_eq("async_rst_ctl", {mem_req, busy, i_ack, d_ack, mem_we}, 0);
    check_eq("async_rst_mem", {mem_addr, mem_wstrb}, 0);
    d_req = 0;
    @(negedge clk);
    rst = 0;
    m_last_d = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("post_rst_noack", {i_ack, d_ack, busy}, 0);
    end

    // reset restores the fetch-first tie rule
    rand_fields();
    run_txn(1, 1, 1, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
